// File: rtl/nlc_result_serializer.sv
// ============================================================================
// nlc_result_serializer
// ----------------------------------------------------------------------------
// Receiving end of the NLC_wrapper output handshake. A full NUM_CH-channel
// x_lin frame is captured on an srdyi_port pulse and then streamed one channel
// per beat (channel 0 first) over a valid/ready handshake. A frame arriving
// while the previous one is still draining is dropped and flagged on a sticky
// overrun bit. A frame arriving on the very beat that retires the last channel
// is accepted back-to-back with no idle bubble.
//
// Optional build macro:
//   NLC_SER_FRAME_TAG_EN - adds frame_tag_o_port, an 8-bit count of captured
//                          frames (wraps mod 256), valid alongside srdyo_port.
//
// Ports:
//   clk_port          in   1          clock, rising edge
//   reset_port        in   1          synchronous active-high reset
//   srdyi_port        in   1          frame-valid pulse from NLC srdyo_port
//   x_lin_bus_i_port  in   NUM_CH*DW  flattened frame, ch n at [n*DW +: DW]
//   drdyi_port        in   1          downstream ready
//   ovr_clr_i_port    in   1          clears the sticky overrun flag
//   x_lin_o_port      out  DW         current channel sample (registered)
//   ch_idx_o_port     out  IDXW       channel index of x_lin_o_port
//   srdyo_port        out  1          output beat valid
//   last_o_port       out  1          high with the beat of channel NUM_CH-1
//   busy_o_port       out  1          frame buffer occupied
//   overrun_o_port    out  1          sticky overrun flag
//   frame_tag_o_port  out  8          captured-frame tag (macro only)
// ============================================================================
module nlc_result_serializer #(
    parameter int NUM_CH = 16,
    parameter int DW     = 21,
    parameter int IDXW   = 4
) (
    input  logic                 clk_port,
    input  logic                 reset_port,
    input  logic                 srdyi_port,
    input  logic [NUM_CH*DW-1:0] x_lin_bus_i_port,
    input  logic                 drdyi_port,
    input  logic                 ovr_clr_i_port,
    output logic [DW-1:0]        x_lin_o_port,
    output logic [IDXW-1:0]      ch_idx_o_port,
    output logic                 srdyo_port,
    output logic                 last_o_port,
    output logic                 busy_o_port,
    output logic                 overrun_o_port
`ifdef NLC_SER_FRAME_TAG_EN
    ,
    output logic [7:0]           frame_tag_o_port
`endif
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DW-1:0]     frame_buf [NUM_CH];
    logic [IDXW-1:0]   idx;
    logic [IDXW-1:0]   idx_inc;
    logic              at_last;
    logic              xfer;
    logic              capture;
    logic              drop;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first, so no path through
    // the block can leave a value unassigned and infer a latch.
    always_comb begin
        at_last = 1'b0;
        xfer    = 1'b0;
        capture = 1'b0;
        drop    = 1'b0;
        idx_inc = idx + IDXW'(1);

        at_last = (state == ST_SEND) && (idx == IDXW'(NUM_CH - 1));
        xfer    = (state == ST_SEND) && drdyi_port;
        // A new frame is only accepted into an empty buffer, or on the edge
        // that retires the final channel (back-to-back, no bubble).
        capture = srdyi_port && ((state == ST_IDLE) || (xfer && at_last));
        // Anything else arriving while busy is lost.
        drop    = srdyi_port && !capture;
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_port) begin
        if (reset_port) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (capture) state_nxt = ST_SEND;
            ST_SEND: if (xfer && at_last && !capture) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Frame buffer
    // ------------------------------------------------------------------------
    // NOTE: the buffer array carries no reset; validity is tracked by the FSM,
    // so clearing the storage itself would only cost reset fan-out.
    always_ff @(posedge clk_port) begin
        if (capture && !reset_port) begin
            for (int c = 0; c < NUM_CH; c++) begin
                frame_buf[c] <= x_lin_bus_i_port[c*DW +: DW];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Index, registered sample and overrun flag
    // ------------------------------------------------------------------------
    // x_lin_o_port is loaded with the sample for the index it will carry next,
    // so data and index always move together and simply hold under stall.
    always_ff @(posedge clk_port) begin
        if (reset_port) begin
            idx            <= '0;
            x_lin_o_port   <= '0;
            overrun_o_port <= 1'b0;
        end else begin
            if (capture) begin
                idx          <= '0;
                x_lin_o_port <= x_lin_bus_i_port[DW-1:0];
            end else if (xfer) begin
                if (at_last) begin
                    idx          <= '0;
                    x_lin_o_port <= '0;
                end else begin
                    idx          <= idx_inc;
                    x_lin_o_port <= frame_buf[idx_inc];
                end
            end

            // Set has priority over clear.
            if (drop) begin
                overrun_o_port <= 1'b1;
            end else if (ovr_clr_i_port) begin
                overrun_o_port <= 1'b0;
            end
        end
    end

`ifdef NLC_SER_FRAME_TAG_EN
    always_ff @(posedge clk_port) begin
        if (reset_port) begin
            frame_tag_o_port <= 8'd0;
        end else if (capture) begin
            frame_tag_o_port <= frame_tag_o_port + 8'd1;
        end
    end
`endif

    assign srdyo_port    = (state == ST_SEND);
    assign busy_o_port   = (state == ST_SEND);
    assign last_o_port   = at_last;
    assign ch_idx_o_port = idx;

endmodule

// File: doc/nlc_result_serializer.md
Name: nlc_result_serializer

Overview:
Receiving end of the NLC_wrapper output handshake. It captures one 16-channel result frame (x_lin, 21 bits per channel) when srdyo from the NLC is pulsed. It then streams the frame one channel per beat, channel 0 first, to a downstream consumer over a valid/ready handshake. It sits between NLC_wrapper and the host readback/DMA path, and flags frames that arrive while the previous frame is still draining.

Parameters:
NUM_CH, 16, number of channels per frame (power of 2, 2..16)
DW, 21, width of one x_lin sample
IDXW, 4, channel index width, equal to log2(NUM_CH)

Ports:
clk_port  in  1  clock, all logic on rising edge
reset_port  in  1  synchronous, active-high reset
srdyi_port  in  1  frame-valid pulse; connects to NLC srdyo_port
x_lin_bus_i_port  in  NUM_CH*DW  flattened frame; channel n occupies bits [n*DW+DW-1 : n*DW]
drdyi_port  in  1  downstream ready
ovr_clr_i_port  in  1  clears sticky overrun flag
x_lin_o_port  out  DW  current channel sample
ch_idx_o_port  out  IDXW  channel index of x_lin_o_port
srdyo_port  out  1  output beat valid
last_o_port  out  1  high with the beat of channel NUM_CH-1
busy_o_port  out  1  frame buffer occupied
overrun_o_port  out  1  sticky overrun flag
frame_tag_o_port  out  8  present only with NLC_SER_FRAME_TAG_EN

Behaviour:
- Reset (reset_port high at a clock edge): all outputs go to 0. FSM goes to IDLE, frame buffer is invalidated, index is cleared to 0. Reset mid-frame discards the remaining beats; no further srdyo until a new capture.
- FSM has two states: IDLE and SEND.
- IDLE: on srdyi_port=1, register the whole bus into the frame buffer, set index to 0, and go to SEND. srdyo_port, busy_o_port and ch_idx_o_port=0 are valid on the next cycle. Latency from capture edge to first beat valid is 1 cycle.
- SEND: srdyo_port=1. x_lin_o_port is buffer[idx] and is a registered output.
- A beat transfers when srdyo_port and drdyi_port are both high at an edge; on transfer, idx increments.
- While srdyo_port=1 and drdyi_port=0, x_lin_o_port, ch_idx_o_port and last_o_port hold stable.
- Transfer with idx=NUM_CH-1 (last_o_port=1): idx wraps to 0.
  - If srdyi_port is not high in that same cycle, return to IDLE; srdyo_port and busy_o_port drop the next cycle.
  - If srdyi_port is high in that same cycle, capture the new frame and stay in SEND with no bubble. This is not an overrun.
- srdyi_port=1 in SEND at any other time: the incoming frame is dropped, the buffer is untouched, and overrun_o_port is set the next cycle.
- overrun_o_port stays set until reset or ovr_clr_i_port=1. If set and clear occur in the same cycle, set wins.
- With drdyi_port tied high, a frame drains in exactly NUM_CH consecutive cycles.
- srdyi_port pulses in IDLE on consecutive cycles: the first is captured; the second (now SEND, idx 0, not last) is an overrun.
- No arithmetic is performed; data passes bit-exact.

Optional Feature:
NLC_SER_FRAME_TAG_EN
- Defined: frame_tag_o_port (8 bits) exists. It resets to 0 and increments (mod 256) on every captured frame, including the back-to-back case. The output is valid alongside srdyo_port, so the first frame streams with tag 1. Dropped frames do not increment it.
- Undefined: the port and counter are absent. All other behaviour is unchanged.

Test Plan:
1. Single frame: ch0=23333, chn=n*1000, drdyi=1, one srdyi pulse. Expect 16 consecutive beats starting 1 cycle after the pulse, ch_idx 0..15, values exact, last_o on beat 15, then srdyo and busy return to 0.
2. Backpressure: drdyi toggles 1,0,0,1 repeating. Data and index hold while drdyi=0, no beat is lost or duplicated, and the total is 16 transfers.
3. Overrun: second srdyi pulse at idx=5. Output continues with the first frame's values, overrun_o=1 from the next cycle, and an ovr_clr pulse returns it to 0. A simultaneous srdyi overrun plus ovr_clr leaves it at 1.
4. Back-to-back: srdyi asserted in the cycle of the beat-15 transfer. The next cycle shows the new frame's ch0 with no idle gap and overrun stays 0. With NLC_SER_FRAME_TAG_EN, tag goes 1 then 2.
5. Reset mid-frame: reset_port high for 1 cycle at idx=7. The next cycle shows all outputs 0 and the FSM in IDLE. A later srdyi streams a fresh frame from idx 0.
6. Reset during srdyi: reset and srdyi both high in the same cycle. No capture occurs and outputs stay 0.
